// File: rtl/dispatch_buffer.sv
// dispatch_buffer
//   In-order instruction buffer sitting between fetch/decode and the
//   execution units. Each entry carries the instruction word, its PC and a
//   one-hot resource class {alu,lsu,muldiv,br}. The head entry is offered to
//   exactly one unit through a valid/ready handshake. A head with a malformed
//   class (zero or multi-hot) is flagged on illegal_o and dropped in the same
//   cycle. A saturating counter records cycles in which a legal head is
//   blocked by its unit.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   flush_i                drop every buffered entry (branch redirect)
//   enq_*                  fetch side: valid/ready, inst, pc, class bits
//   <unit>_valid_o/_ready_i  dispatch handshakes for alu, lsu, muldiv, br
//   disp_inst_o, disp_pc_o head payload shared by all units (0 when empty)
//   illegal_o              head is malformed and is being dropped this cycle
//   count_o                number of occupied entries
//   stall_cnt_o            saturating count of head-blocked cycles
module dispatch_buffer #(
   parameter int DEPTH   = 4,
   parameter int PTR_W   = 2,
   parameter int XLEN    = 32,
   parameter int STALL_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic               enq_valid_i,
   output logic               enq_ready_o,
   input  logic [XLEN-1:0]    enq_inst_i,
   input  logic [XLEN-1:0]    enq_pc_i,
   input  logic               enq_alu_i,
   input  logic               enq_lsu_i,
   input  logic               enq_muldiv_i,
   input  logic               enq_br_i,
   output logic               alu_valid_o,
   input  logic               alu_ready_i,
   output logic               lsu_valid_o,
   input  logic               lsu_ready_i,
   output logic               muldiv_valid_o,
   input  logic               muldiv_ready_i,
   output logic               br_valid_o,
   input  logic               br_ready_i,
   output logic [XLEN-1:0]    disp_inst_o,
   output logic [XLEN-1:0]    disp_pc_o,
   output logic               illegal_o,
   output logic [PTR_W:0]     count_o,
   output logic [STALL_W-1:0] stall_cnt_o
);

   // class bit positions inside the 4-bit class field
   localparam int C_ALU = 3;
   localparam int C_LSU = 2;
   localparam int C_MD  = 1;
   localparam int C_BR  = 0;

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [DEPTH-1:0][XLEN-1:0] inst_q;
   logic [DEPTH-1:0][XLEN-1:0] pc_q;
   logic [DEPTH-1:0][3:0]      cls_q;
   logic [PTR_W-1:0]           head_q;
   logic [PTR_W-1:0]           tail_q;
   logic [PTR_W:0]             count_q;
   logic [STALL_W-1:0]         stall_q;

   logic       not_empty;
   logic       legal;
   logic       push;
   logic       pop;
   logic       sel_ready;
   logic       stall;
   logic [3:0] head_cls;
   logic [3:0] unit_valid;
   logic [3:0] unit_ready;

   always_comb begin
      not_empty  = (count_q != '0);
      head_cls   = cls_q[head_q];
      // exactly one bit set: non-zero and clearing the lowest set bit leaves zero
      legal      = (head_cls != 4'b0) && ((head_cls & (head_cls - 4'd1)) == 4'b0);
      // valids come from registered state only; readies never feed back into them
      unit_valid = (not_empty && legal) ? head_cls : 4'b0;
      unit_ready = {alu_ready_i, lsu_ready_i, muldiv_ready_i, br_ready_i};
      sel_ready  = |(unit_valid & unit_ready);
      // a malformed head is dropped regardless of any ready input
      pop        = (not_empty && !legal) || sel_ready;
      stall      = not_empty && legal && !sel_ready;
      push       = enq_valid_i && (count_q != FULL_CNT);
   end

   assign enq_ready_o    = (count_q != FULL_CNT);
   assign alu_valid_o    = unit_valid[C_ALU];
   assign lsu_valid_o    = unit_valid[C_LSU];
   assign muldiv_valid_o = unit_valid[C_MD];
   assign br_valid_o     = unit_valid[C_BR];
   assign illegal_o      = not_empty && !legal;
   assign disp_inst_o    = not_empty ? inst_q[head_q] : '0;
   assign disp_pc_o      = not_empty ? pc_q[head_q]   : '0;
   assign count_o        = count_q;
   assign stall_cnt_o    = stall_q;

   // control state and class fields; flush only touches occupancy, the
   // stall counter keeps counting through it
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         stall_q <= '0;
         cls_q   <= '0;
      end else begin
         if (stall && (stall_q != '1))
            stall_q <= stall_q + STALL_W'(1);
         if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            if (push) begin
               cls_q[tail_q] <= {enq_alu_i, enq_lsu_i, enq_muldiv_i, enq_br_i};
               tail_q        <= tail_q + PTR_W'(1);
            end
            if (pop)
               head_q <= head_q + PTR_W'(1);
            case ({push, pop})
               2'b10:   count_q <= count_q + (PTR_W+1)'(1);
               2'b01:   count_q <= count_q - (PTR_W+1)'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

   // payload storage needs no reset: it is only visible while count != 0
   always_ff @(posedge clk_i) begin
      if (push) begin
         inst_q[tail_q] <= enq_inst_i;
         pc_q[tail_q]   <= enq_pc_i;
      end
   end

endmodule

// File: tb/tb_dispatch_buffer.sv
module tb_dispatch_buffer;

   localparam int DEPTH   = 4;
   localparam int PTR_W   = 2;
   localparam int XLEN    = 32;
   localparam int STALL_W = 4;

   logic               clk = 1'b0;
   logic               rst_i = 1'b1;
   logic               flush_i = 1'b0;
   logic               enq_valid_i = 1'b0;
   logic               enq_ready_o;
   logic [XLEN-1:0]    enq_inst_i = '0;
   logic [XLEN-1:0]    enq_pc_i = '0;
   logic               enq_alu_i = 1'b0, enq_lsu_i = 1'b0, enq_muldiv_i = 1'b0, enq_br_i = 1'b0;
   logic               alu_valid_o, lsu_valid_o, muldiv_valid_o, br_valid_o;
   logic               alu_ready_i = 1'b0, lsu_ready_i = 1'b0, muldiv_ready_i = 1'b0, br_ready_i = 1'b0;
   logic [XLEN-1:0]    disp_inst_o, disp_pc_o;
   logic               illegal_o;
   logic [PTR_W:0]     count_o;
   logic [STALL_W-1:0] stall_cnt_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dispatch_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W), .XLEN(XLEN), .STALL_W(STALL_W)) dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
      .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
      .enq_inst_i(enq_inst_i), .enq_pc_i(enq_pc_i),
      .enq_alu_i(enq_alu_i), .enq_lsu_i(enq_lsu_i), .enq_muldiv_i(enq_muldiv_i), .enq_br_i(enq_br_i),
      .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
      .lsu_valid_o(lsu_valid_o), .lsu_ready_i(lsu_ready_i),
      .muldiv_valid_o(muldiv_valid_o), .muldiv_ready_i(muldiv_ready_i),
      .br_valid_o(br_valid_o), .br_ready_i(br_ready_i),
      .disp_inst_o(disp_inst_o), .disp_pc_o(disp_pc_o),
      .illegal_o(illegal_o), .count_o(count_o), .stall_cnt_o(stall_cnt_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: a plain queue of entries ----------------
   typedef struct {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
      logic [3:0]      cls;   // {alu,lsu,muldiv,br}
   } ent_t;

   ent_t m_q[$];
   int   m_stall = 0;
   bit   model_ok = 0;

   logic [3:0]      e_valid, rdy;
   logic            e_illegal, e_ready, e_legal, e_pop, e_push;
   logic [XLEN-1:0] e_inst, e_pc;
   ent_t            nent;

   always @(negedge clk) begin
      rdy = {alu_ready_i, lsu_ready_i, muldiv_ready_i, br_ready_i};
      e_valid = 4'b0; e_illegal = 1'b0; e_legal = 1'b0; e_inst = '0; e_pc = '0;
      if (m_q.size() > 0) begin
         e_legal   = ($countones(m_q[0].cls) == 1);
         e_valid   = e_legal ? m_q[0].cls : 4'b0;
         e_illegal = !e_legal;
         e_inst    = m_q[0].inst;
         e_pc      = m_q[0].pc;
      end
      e_ready = (m_q.size() < DEPTH);
      if (model_ok) begin
         check("m_alu_valid",    64'(alu_valid_o),    64'(e_valid[3]));
         check("m_lsu_valid",    64'(lsu_valid_o),    64'(e_valid[2]));
         check("m_muldiv_valid", 64'(muldiv_valid_o), 64'(e_valid[1]));
         check("m_br_valid",     64'(br_valid_o),     64'(e_valid[0]));
         check("m_illegal",      64'(illegal_o),      64'(e_illegal));
         check("m_enq_ready",    64'(enq_ready_o),    64'(e_ready));
         check("m_inst",         64'(disp_inst_o),    64'(e_inst));
         check("m_pc",           64'(disp_pc_o),      64'(e_pc));
         check("m_count",        64'(count_o),        64'(m_q.size()));
         check("m_stall",        64'(stall_cnt_o),    64'(m_stall));
      end
      // advance model to the state after the coming edge (inputs are stable until then)
      if (rst_i) begin
         m_q.delete();
         m_stall  = 0;
         model_ok = 1;
      end else if (model_ok) begin
         e_pop  = e_illegal || ((e_valid & rdy) != 4'b0);
         e_push = enq_valid_i && e_ready;
         if (e_valid != 4'b0 && (e_valid & rdy) == 4'b0 && m_stall < (1 << STALL_W) - 1)
            m_stall++;
         if (flush_i) m_q.delete();
         else begin
            if (e_pop) void'(m_q.pop_front());
            if (e_push) begin
               nent.inst = enq_inst_i;
               nent.pc   = enq_pc_i;
               nent.cls  = {enq_alu_i, enq_lsu_i, enq_muldiv_i, enq_br_i};
               m_q.push_back(nent);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_enq(input logic v, input logic [31:0] inst, input logic [31:0] pc, input logic [3:0] cls);
      enq_valid_i = v;
      enq_inst_i  = inst;
      enq_pc_i    = pc;
      {enq_alu_i, enq_lsu_i, enq_muldiv_i, enq_br_i} = cls;
   endtask

   task automatic set_rdy(input logic [3:0] r);
      {alu_ready_i, lsu_ready_i, muldiv_ready_i, br_ready_i} = r;
   endtask

   task automatic push1(input logic [31:0] inst, input logic [31:0] pc, input logic [3:0] cls);
      set_enq(1'b1, inst, pc, cls);
      step();
      set_enq(1'b0, '0, '0, 4'b0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_enq_ready"}, 64'(enq_ready_o), 64'd1);
      check({tag, "_valids"}, 64'({alu_valid_o, lsu_valid_o, muldiv_valid_o, br_valid_o}), 64'd0);
      check({tag, "_illegal"}, 64'(illegal_o), 64'd0);
      check({tag, "_inst"}, 64'(disp_inst_o), 64'd0);
      check({tag, "_pc"}, 64'(disp_pc_o), 64'd0);
      check({tag, "_count"}, 64'(count_o), 64'd0);
      check({tag, "_stall"}, 64'(stall_cnt_o), 64'd0);
   endtask

   initial begin
      logic [3:0] c;
      // reset
      rst_i = 1'b1; step(); step(); rst_i = 1'b0;
      check_reset_vals("rst");

      // 1: single ALU entry blocked for three cycles
      push1(32'h00A00093, 32'h100, 4'b1000);
      check("t1_alu_valid", 64'(alu_valid_o), 64'd1);
      check("t1_pc", 64'(disp_pc_o), 64'h100);
      step(); step(); step();
      check("t1_stall", 64'(stall_cnt_o), 64'd3);
      set_rdy(4'b1000); step(); set_rdy(4'b0);
      check("t1_count", 64'(count_o), 64'd0);

      // 2: fill, reject fifth, drain in order
      push1(32'h1, 32'h200, 4'b0100);
      push1(32'h2, 32'h204, 4'b0010);
      push1(32'h3, 32'h208, 4'b1000);
      push1(32'h4, 32'h20C, 4'b0001);
      check("t2_count_full", 64'(count_o), 64'd4);
      check("t2_enq_ready", 64'(enq_ready_o), 64'd0);
      push1(32'h5, 32'h210, 4'b1000);
      check("t2_count_after5", 64'(count_o), 64'd4);
      set_rdy(4'b1111);
      check("t2_lsu", 64'({lsu_valid_o, disp_pc_o}), {31'd0, 1'b1, 32'h200});
      step();
      check("t2_muldiv", 64'({muldiv_valid_o, disp_pc_o}), {31'd0, 1'b1, 32'h204});
      step();
      check("t2_alu", 64'({alu_valid_o, disp_pc_o}), {31'd0, 1'b1, 32'h208});
      step();
      check("t2_br", 64'({br_valid_o, disp_pc_o}), {31'd0, 1'b1, 32'h20C});
      step();
      set_rdy(4'b0);
      check("t2_empty", 64'(count_o), 64'd0);

      // 3: malformed classes are dropped without any ready
      push1(32'h30, 32'h300, 4'b0000);
      check("t3_ill0", 64'({illegal_o, disp_pc_o}), {31'd0, 1'b1, 32'h300});
      push1(32'h31, 32'h304, 4'b1100);
      check("t3_ill1", 64'({illegal_o, disp_pc_o}), {31'd0, 1'b1, 32'h304});
      push1(32'h32, 32'h308, 4'b1000);
      check("t3_alu", 64'({illegal_o, alu_valid_o, disp_pc_o}), {30'd0, 2'b01, 32'h308});
      set_rdy(4'b1000); step(); set_rdy(4'b0);

      // 4: steady push+pop at count 2, pointers wrap
      push1(32'h40, 32'h400, 4'b1000);
      push1(32'h41, 32'h404, 4'b1000);
      set_rdy(4'b1000);
      for (int k = 0; k < 6; k++) begin
         check("t4_count", 64'(count_o), 64'd2);
         check("t4_pc", 64'(disp_pc_o), 64'(32'h400 + 4 * k));
         set_enq(1'b1, 32'h42 + k, 32'h408 + 4 * k, 4'b1000);
         step();
      end
      set_enq(1'b0, '0, '0, 4'b0);
      check("t4_pc_tail", 64'(disp_pc_o), 64'h418);
      step(); step();
      set_rdy(4'b0);
      check("t4_drained", 64'(count_o), 64'd0);

      // 5: flush overrides push and pop
      push1(32'h50, 32'h500, 4'b1000);
      push1(32'h51, 32'h504, 4'b1000);
      push1(32'h52, 32'h508, 4'b1000);
      flush_i = 1'b1; set_rdy(4'b1000); set_enq(1'b1, 32'h5F, 32'h5FC, 4'b1000);
      step();
      flush_i = 1'b0; set_rdy(4'b0); set_enq(1'b0, '0, '0, 4'b0);
      check("t5_count", 64'(count_o), 64'd0);
      check("t5_valids", 64'({alu_valid_o, lsu_valid_o, muldiv_valid_o, br_valid_o}), 64'd0);
      check("t5_enq_ready", 64'(enq_ready_o), 64'd1);
      push1(32'h60, 32'h600, 4'b1000);
      check("t5_next_pc", 64'(disp_pc_o), 64'h600);
      set_rdy(4'b1000); step(); set_rdy(4'b0);

      // 6: stall counter saturates, reset mid-stall
      push1(32'h70, 32'h700, 4'b0010);
      for (int k = 0; k < 20; k++) step();
      check("t6_sat", 64'(stall_cnt_o), 64'd15);
      rst_i = 1'b1; step(); rst_i = 1'b0;
      check_reset_vals("t6_rst");

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) < 8) c = 4'b0001 << $urandom_range(0, 3);
         else c = 4'($urandom_range(0, 15));
         set_enq(1'($urandom_range(0, 9) < 6), $urandom, $urandom, c);
         set_rdy(4'($urandom_range(0, 15)) & {4{$urandom_range(0, 3) != 0}});
         flush_i = ($urandom_range(0, 49) == 0);
         rst_i   = ($urandom_range(0, 299) == 0);
         step();
      end
      set_enq(1'b0, '0, '0, 4'b0); set_rdy(4'b0); flush_i = 1'b0; rst_i = 1'b0;
      step(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
